// File: rtl/r88_pkg.sv
// Shared constants and state encoding for the r88 interrupt controller.
package r88_pkg;

    localparam int unsigned VEC_W = 16;

    localparam logic [VEC_W-1:0] RST_VEC  = 16'hFFFC;
    localparam logic [VEC_W-1:0] NMI_VEC  = 16'hFFFA;
    localparam logic [VEC_W-1:0] IRQ_VEC  = 16'hFFFE;
    localparam logic [VEC_W-1:0] IDLE_VEC = 16'h0000;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_NMI  = 2'd2,
        ST_IRQ  = 2'd3
    } r88_state_e;

    // Vector presented to the decoder while in a given state.
    function automatic logic [VEC_W-1:0] vec_of(input r88_state_e s);
        logic [VEC_W-1:0] v;
        v = IDLE_VEC;
        case (s)
            ST_RST:  v = RST_VEC;
            ST_NMI:  v = NMI_VEC;
            ST_IRQ:  v = IRQ_VEC;
            default: v = IDLE_VEC;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/r88_sync2.sv
// Two-flop synchronizer for an asynchronous active-low pin; resets to the inactive level.
module r88_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    // Two-stage capture of the asynchronous pin.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            q_o    <= 1'b1;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/r88_int_ctrl.sv
// Reset/NMI/IRQ arbitration towards the r88 decoder with registered one-hot requests.
module r88_int_ctrl
    import r88_pkg::*;
#(
    parameter int unsigned RST_STRETCH = 4
) (
    input  logic              sysClock,
    input  logic              sysReset,
    input  logic              resetPin_n,
    input  logic              nmiPin_n,
    input  logic              irqPin_n,
    input  logic              irqEn,
    input  logic              intAck,
    output logic              resetReq,
    output logic              nmiReq,
    output logic              irq,
    output logic [VEC_W-1:0]  vector
);

    localparam int unsigned CNT_W = (RST_STRETCH < 1) ? 1 : $clog2(RST_STRETCH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_STRETCH);

    logic             rst_pin_s;
    logic             nmi_pin_s;
    logic             irq_pin_s;
    logic             nmi_prev_q;
    logic             nmi_edge;
    logic             nmi_pend;
    logic             irq_act;
    r88_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_hi_q, rst_hi_d;
    logic             pend_q, pend_d;

    r88_sync2 u_sync_rst (.clk_i(sysClock), .rst_i(sysReset), .d_i(resetPin_n), .q_o(rst_pin_s));
    r88_sync2 u_sync_nmi (.clk_i(sysClock), .rst_i(sysReset), .d_i(nmiPin_n),   .q_o(nmi_pin_s));
    r88_sync2 u_sync_irq (.clk_i(sysClock), .rst_i(sysReset), .d_i(irqPin_n),   .q_o(irq_pin_s));

    // A falling synced NMI pin counts as pending in the same cycle it is seen.
    assign nmi_edge = nmi_prev_q & ~nmi_pin_s;
    assign nmi_pend = pend_q | nmi_edge;
    assign irq_act  = ~irq_pin_s & irqEn;

    // Previous synced NMI level for edge detection.
    always_ff @(posedge sysClock or posedge sysReset) begin
        if (sysReset) begin
            nmi_prev_q <= 1'b1;
        end else begin
            nmi_prev_q <= nmi_pin_s;
        end
    end

    // Next-state, stretch counter and pending-latch decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rst_hi_d = rst_hi_q;
        pend_d   = pend_q;
        if (!rst_pin_s) begin
            // Reset pin dominates: reload the stretch and drop any NMI in flight.
            state_d  = ST_RST;
            cnt_d    = CNT_LOAD;
            rst_hi_d = 1'b0;
            pend_d   = 1'b0;
        end else begin
            case (state_q)
                ST_RST: begin
                    // The first high cycle reloads; counting starts once the pin has been seen high.
                    pend_d   = 1'b0;
                    rst_hi_d = 1'b1;
                    if (!rst_hi_q) begin
                        cnt_d = CNT_LOAD;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    pend_d = nmi_pend;
                    if (nmi_pend) begin
                        state_d = ST_NMI;
                    end else if (irq_act) begin
                        state_d = ST_IRQ;
                    end
                end
                ST_NMI: begin
                    // An edge coincident with the ack re-arms the latch.
                    if (intAck) begin
                        pend_d  = nmi_edge;
                        state_d = ST_IDLE;
                    end else begin
                        pend_d = nmi_pend;
                    end
                end
                ST_IRQ: begin
                    pend_d = nmi_pend;
                    if (intAck) begin
                        state_d = ST_IDLE;
                    end else if (nmi_pend) begin
                        state_d = ST_NMI;
                    end else if (!irq_act) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_RST;
                end
            endcase
        end
    end

    // State, counter, latch and registered decoder outputs.
    always_ff @(posedge sysClock or posedge sysReset) begin
        if (sysReset) begin
            state_q  <= ST_RST;
            cnt_q    <= CNT_LOAD;
            rst_hi_q <= 1'b0;
            pend_q   <= 1'b0;
            resetReq <= 1'b1;
            nmiReq   <= 1'b0;
            irq      <= 1'b0;
            vector   <= RST_VEC;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rst_hi_q <= rst_hi_d;
            pend_q   <= pend_d;
            resetReq <= (state_d == ST_RST);
            nmiReq   <= (state_d == ST_NMI);
            irq      <= (state_d == ST_IRQ);
            vector   <= vec_of(state_d);
        end
    end

endmodule

// File: tb/tb_r88_int_ctrl.sv
// Self-checking bench for r88_int_ctrl: directed scenarios plus randomized pins against a request-level model.
module tb_r88_int_ctrl;

    localparam int unsigned N = 4;

    logic        sysClock = 1'b0;
    logic        sysReset = 1'b1;
    logic        resetPin_n = 1'b1;
    logic        nmiPin_n = 1'b1;
    logic        irqPin_n = 1'b1;
    logic        irqEn = 1'b0;
    logic        intAck = 1'b0;
    logic        resetReq;
    logic        nmiReq;
    logic        irq;
    logic [15:0] vector;

    int checks = 0;
    int errors = 0;

    always #5 sysClock = ~sysClock;

    r88_int_ctrl #(.RST_STRETCH(N)) dut (
        .sysClock   (sysClock),
        .sysReset   (sysReset),
        .resetPin_n (resetPin_n),
        .nmiPin_n   (nmiPin_n),
        .irqPin_n   (irqPin_n),
        .irqEn      (irqEn),
        .intAck     (intAck),
        .resetReq   (resetReq),
        .nmiReq     (nmiReq),
        .irq        (irq),
        .vector     (vector)
    );

    // Request model: 0 none, 1 reset, 2 NMI, 3 IRQ.
    int m_pres   = 1;
    bit m_pend   = 1'b0;
    int m_hi_run = 0;
    bit r_a = 1'b1, r_b = 1'b1;
    bit n_a = 1'b1, n_b = 1'b1;
    bit i_a = 1'b1, i_b = 1'b1;
    bit n_prev = 1'b1;
    bit m_nfall;
    bit m_act;

    always @(posedge sysClock or posedge sysReset) begin
        if (sysReset) begin
            m_pres = 1; m_pend = 1'b0; m_hi_run = 0;
            r_a = 1'b1; r_b = 1'b1; n_a = 1'b1; n_b = 1'b1; i_a = 1'b1; i_b = 1'b1;
            n_prev = 1'b1;
        end else begin
            m_nfall = n_prev && !n_b;
            m_act   = !i_b && (irqEn === 1'b1);
            if (!r_b) begin
                m_pres = 1; m_pend = 1'b0; m_hi_run = 0;
            end else if (m_pres == 1) begin
                // Released once the pin has been seen high for N+2 consecutive edges.
                m_pend = 1'b0;
                m_hi_run++;
                if (m_hi_run == int'(N) + 2) m_pres = 0;
            end else if (m_pres == 2 && intAck === 1'b1) begin
                m_pend = m_nfall;
                m_pres = 0;
            end else begin
                m_pend = m_pend || m_nfall;
                if (m_pres == 3 && intAck === 1'b1) m_pres = 0;
                else if (m_pend)                    m_pres = 2;
                else if (m_act)                     m_pres = 3;
                else                                m_pres = 0;
            end
            n_prev = n_b;
            r_b = r_a; r_a = resetPin_n;
            n_b = n_a; n_a = nmiPin_n;
            i_b = i_a; i_a = irqPin_n;
        end
    end

    function automatic logic [15:0] exp_vec(input int p);
        logic [15:0] v;
        v = 16'h0000;
        if (p == 1) v = 16'hFFFC;
        if (p == 2) v = 16'hFFFA;
        if (p == 3) v = 16'hFFFE;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge sysClock) begin
        chk("m_resetReq", 32'(resetReq), 32'(m_pres == 1));
        chk("m_nmiReq",   32'(nmiReq),   32'(m_pres == 2));
        chk("m_irq",      32'(irq),      32'(m_pres == 3));
        chk("m_vector",   32'(vector),   32'(exp_vec(m_pres)));
    end

    task automatic step();
        @(posedge sysClock);
        #2;
    endtask

    task automatic stepn(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    int n;

    initial begin
        // Power-on reset
        stepn(2);
        chk("por_resetReq", 32'(resetReq), 32'd1);
        chk("por_vector",   32'(vector),   32'hFFFC);
        chk("por_nmiReq",   32'(nmiReq),   32'd0);
        chk("por_irq",      32'(irq),      32'd0);
        sysReset = 1'b0;
        n = 0;
        while (resetReq === 1'b1 && n < 20) begin step(); n++; end
        chk("por_release_cycles", 32'(n), 32'(N + 2));
        chk("idle_vector", 32'(vector), 32'h0000);

        // NMI presentation and merging of a second edge
        nmiPin_n = 1'b0;
        stepn(2);
        chk("nmi_c2", 32'(nmiReq), 32'd0);
        step();
        chk("nmi_c3", 32'(nmiReq), 32'd1);
        chk("nmi_vec", 32'(vector), 32'hFFFA);
        nmiPin_n = 1'b1; stepn(3);
        nmiPin_n = 1'b0; stepn(4);
        chk("nmi_held", 32'(nmiReq), 32'd1);
        intAck = 1'b1; step(); intAck = 1'b0;
        chk("nmi_ack", 32'(nmiReq), 32'd0);
        stepn(5);
        chk("nmi_merged", 32'(nmiReq), 32'd0);

        // IRQ level request dropped by irqEn
        irqPin_n = 1'b0; irqEn = 1'b1;
        stepn(2);
        chk("irq_c2", 32'(irq), 32'd0);
        step();
        chk("irq_c3", 32'(irq), 32'd1);
        chk("irq_vec", 32'(vector), 32'hFFFE);
        irqEn = 1'b0; step();
        chk("irq_mask_drop", 32'(irq), 32'd0);

        // NMI preempting a presented IRQ
        nmiPin_n = 1'b1; irqEn = 1'b1; step();
        chk("irq_again", 32'(irq), 32'd1);
        stepn(2);
        nmiPin_n = 1'b0; stepn(2);
        chk("pre_irq", 32'(irq), 32'd1);
        step();
        chk("preempt_irq", 32'(irq), 32'd0);
        chk("preempt_nmi", 32'(nmiReq), 32'd1);
        chk("preempt_vec", 32'(vector), 32'hFFFA);

        // Ack coincident with a fresh synced NMI edge
        nmiPin_n = 1'b1; stepn(3);
        nmiPin_n = 1'b0; stepn(2);
        intAck = 1'b1; step(); intAck = 1'b0;
        chk("ack_edge_exit", 32'(nmiReq), 32'd0);
        step();
        chk("ack_edge_rearm", 32'(nmiReq), 32'd1);
        irqEn = 1'b0; intAck = 1'b1; step(); intAck = 1'b0;
        step();

        // Reset pin cancels a pending NMI
        nmiPin_n = 1'b1; stepn(3);
        nmiPin_n = 1'b0; stepn(3);
        chk("nmi_before_rst", 32'(nmiReq), 32'd1);
        resetPin_n = 1'b0; stepn(3);
        chk("pin_rst_req", 32'(resetReq), 32'd1);
        chk("pin_rst_nmi", 32'(nmiReq), 32'd0);
        resetPin_n = 1'b1;
        n = 0;
        while (resetReq === 1'b1 && n < 30) begin step(); n++; end
        chk("pin_rst_release", 32'(resetReq), 32'd0);
        stepn(5);
        chk("no_nmi_after_rst", 32'(nmiReq), 32'd0);

        // Randomized pins, acks and resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0)  nmiPin_n = ~nmiPin_n;
            if ($urandom_range(9) == 0)  irqPin_n = ~irqPin_n;
            if ($urandom_range(11) == 0) irqEn    = ~irqEn;
            intAck = ($urandom_range(4) == 0);
            if (resetPin_n == 1'b0) begin
                if ($urandom_range(2) == 0) resetPin_n = 1'b1;
            end else if ($urandom_range(149) == 0) begin
                resetPin_n = 1'b0;
            end
            if (sysReset == 1'b1) sysReset = 1'b0;
            else if ($urandom_range(699) == 0) sysReset = 1'b1;
            step();
        end
        sysReset = 1'b0; intAck = 1'b0;
        stepn(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
